// File: rtl/rv32m_pkg.sv
// Shared funct3 encodings, FSM states and constants for the RV32M multiply/divide unit.
package rv32m_pkg;
  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_MULHU  = 3'd3;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_DIVU   = 3'd5;
  localparam logic [2:0] F_REM    = 3'd6;
  localparam logic [2:0] F_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction
endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, emit a quotient bit.
module div_restoring_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] div_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);
  logic [32:0] shifted;
  logic        ge;

  assign shifted = {rem_i, quo_i[31]};
  assign ge      = shifted >= {1'b0, div_i};
  // When ge holds the difference is below the divisor, so the low 32 bits are exact.
  assign rem_o   = ge ? (shifted[31:0] - div_i) : shifted[31:0];
  assign quo_o   = {quo_i[30:0], ge};
endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage iterative RV32M multiply/divide unit: one bit per cycle, stalls the pipe while busy.
module ex_muldiv_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StartE,
  input  logic [2:0]      FunctE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            HoldE,
  input  logic            Kill,
  output logic            BusyE,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultE
);
  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic [2:0]  funct_q;
  logic        sa_q, sb_q;
  logic [31:0] opnd_q;
  logic [63:0] acc_q, acc_d;
  logic        load_op;

  logic        a_signed, b_signed, sa, sb;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, div_ovf;
  logic [31:0] fast_res;
  logic [32:0] mul_sum;
  logic [63:0] mul_next, mul_prod;
  logic [31:0] mul_res, rem_nx, quo_nx, div_res;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (FunctE)
      F_MUL, F_MULH, F_DIV, F_REM: begin a_signed = 1'b1; b_signed = 1'b1; end
      F_MULHSU:                    begin a_signed = 1'b1; b_signed = 1'b0; end
      F_MULHU, F_DIVU, F_REMU:     begin a_signed = 1'b0; b_signed = 1'b0; end
      default:                     begin a_signed = 1'b0; b_signed = 1'b0; end
    endcase
  end

  assign sa       = a_signed & SrcAE[31];
  assign sb       = b_signed & SrcBE[31];
  assign a_mag    = neg_if(SrcAE, sa);
  assign b_mag    = neg_if(SrcBE, sb);
  assign div_zero = (SrcBE == '0);
  assign div_ovf  = ((FunctE == F_DIV) || (FunctE == F_REM)) && (SrcAE == INT_MIN) && (SrcBE == '1);
  assign fast_res = div_zero ? (FunctE[1] ? SrcAE : DIV_ZERO_Q) : (FunctE[1] ? '0 : INT_MIN);

  // Multiplier sits in acc[31:0] and retires one bit per cycle as the partial product shifts in.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};
  assign mul_prod = (sa_q ^ sb_q) ? (~mul_next + 64'd1) : mul_next;
  assign mul_res  = (funct_q == F_MUL) ? mul_prod[31:0] : mul_prod[63:32];

  div_restoring_step u_div_step (
    .rem_i (acc_q[63:32]),
    .quo_i (acc_q[31:0]),
    .div_i (opnd_q),
    .rem_o (rem_nx),
    .quo_o (quo_nx)
  );

  assign div_res = funct_q[1] ? neg_if(rem_nx, sa_q) : neg_if(quo_nx, sa_q ^ sb_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    acc_d   = acc_q;
    load_op = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (StartE) begin
          if (FunctE[2] && (div_zero || div_ovf)) begin
            state_d = S_DONE;
            res_d   = fast_res;
          end else begin
            state_d = FunctE[2] ? S_DIV : S_MUL;
            cnt_d   = 5'd31;
            acc_d   = {32'd0, FunctE[2] ? a_mag : b_mag};
            load_op = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = S_DONE;
          res_d   = mul_res;
        end
      end
      S_DIV: begin
        acc_d = {rem_nx, quo_nx};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = S_DONE;
          res_d   = div_res;
        end
      end
      S_DONE: begin
        if (!HoldE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (Kill) begin
      state_d = S_IDLE;
      cnt_d   = cnt_q;
      res_d   = res_q;
      acc_d   = acc_q;
      load_op = 1'b0;
    end
  end

  assign BusyE   = !rst && (((state_q == S_IDLE) && StartE && !Kill) ||
                            (state_q == S_MUL) || (state_q == S_DIV));
  assign DoneE   = (state_q == S_DONE);
  assign ResultE = res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    if (load_op) begin
      funct_q <= FunctE;
      sa_q    <= sa;
      sb_q    <= sb;
      opnd_q  <= FunctE[2] ? b_mag : a_mag;
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases, hold/kill/reset scenarios, random ops.
module tb_ex_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, StartE, HoldE, Kill;
  logic [2:0]  FunctE;
  logic [31:0] SrcAE, SrcBE;
  logic        BusyE, DoneE;
  logic [31:0] ResultE;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .StartE(StartE), .FunctE(FunctE), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .HoldE(HoldE), .Kill(Kill), .BusyE(BusyE), .DoneE(DoneE), .ResultE(ResultE)
  );

  // Reference: plain 64-bit arithmetic plus the RISC-V divide corner-case rules.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    ref_op = '0;
    case (f)
      3'd0: begin p = sa * sb; ref_op = p[31:0]; end
      3'd1: begin p = sa * sb; ref_op = p[63:32]; end
      3'd2: begin p = sa * ub; ref_op = p[63:32]; end
      3'd3: begin p = ua * ub; ref_op = p[63:32]; end
      3'd4: ref_op = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: ref_op = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: ref_op = (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      default: ref_op = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Presents an op at the next falling edge and counts cycles until DoneE (bounded).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy, output logic seen);
    @(negedge clk);
    FunctE = f; SrcAE = a; SrcBE = b; StartE = 1'b1; HoldE = 1'b0; Kill = 1'b0;
    #1;
    lat = 0;
    busy = 0;
    while (DoneE !== 1'b1 && lat < 100) begin
      if (BusyE === 1'b1) busy++;
      @(negedge clk);
      #1;
      lat++;
    end
    seen = (DoneE === 1'b1);
    res = ResultE;
  endtask

  task automatic test_reset();
    rst = 1'b1; StartE = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (BusyE !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BusyE); end
    checks++; if (DoneE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", DoneE); end
    checks++; if (ResultE !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", ResultE); end
    StartE = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (BusyE !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", BusyE); end
    last_res = 32'd0;
  endtask

  task automatic test_directed();
    vec_t vecs[12];
    vec_t v;
    logic [31:0] res;
    int lat, busy;
    logic seen;
    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[2]  = '{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[5]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    vecs[6]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[7]  = '{3'd7, 32'd5,          32'd0,         32'd5,         1};
    vecs[8]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
    vecs[9]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
    vecs[10] = '{3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1};
    vecs[11] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1};
    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      run_op(v.f, v.a, v.b, res, lat, busy, seen);
      checks++; if (!seen) begin errors++; $display("FAIL dir%0d_done: no DoneE within %0d cycles", i, lat); end
      checks++; if (res !== v.exp) begin errors++; $display("FAIL dir%0d_result: got %h expected %h", i, res, v.exp); end
      checks++; if (lat != v.lat) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, v.lat); end
      checks++; if (busy != v.lat) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, busy, v.lat); end
      checks++; if (BusyE !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_in_done: got %b expected 0", i, BusyE); end
      last_res = v.exp;
    end
  endtask

  task automatic test_hold();
    logic [31:0] res, exp;
    int lat, busy, ndone;
    logic seen;
    exp = ref_op(3'd0, 32'd12345, 32'hFFFF_0003);
    run_op(3'd0, 32'd12345, 32'hFFFF_0003, res, lat, busy, seen);
    checks++; if (res !== exp) begin errors++; $display("FAIL hold_result: got %h expected %h", res, exp); end
    HoldE = 1'b1;
    ndone = seen ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) begin HoldE = 1'b0; StartE = 1'b0; end
      #1;
      if (DoneE === 1'b1) ndone++;
      checks++; if (BusyE !== 1'b0) begin errors++; $display("FAIL hold_busy%0d: got %b expected 0", i, BusyE); end
      checks++; if (ResultE !== exp) begin errors++; $display("FAIL hold_result%0d: got %h expected %h", i, ResultE, exp); end
    end
    checks++; if (ndone != 4) begin errors++; $display("FAIL hold_done_cycles: got %0d expected 4", ndone); end
    @(negedge clk);
    #1;
    checks++; if (DoneE !== 1'b0) begin errors++; $display("FAIL hold_release_done: got %b expected 0", DoneE); end
    checks++; if (BusyE !== 1'b0) begin errors++; $display("FAIL hold_release_busy: got %b expected 0", BusyE); end
    last_res = exp;
  endtask

  task automatic test_kill();
    logic [31:0] res, exp, a, b;
    int lat, busy, ndone;
    logic seen;
    a = $urandom;
    b = 32'($urandom_range(1, 1000));
    @(negedge clk);
    FunctE = 3'd4; SrcAE = a; SrcBE = b; StartE = 1'b1; HoldE = 1'b0; Kill = 1'b0;
    repeat (10) @(negedge clk);
    Kill = 1'b1;
    #1;
    checks++; if (BusyE !== 1'b1) begin errors++; $display("FAIL kill_busy_at_k: got %b expected 1", BusyE); end
    @(negedge clk);
    Kill = 1'b0; StartE = 1'b0;
    #1;
    checks++; if (BusyE !== 1'b0) begin errors++; $display("FAIL kill_busy_after: got %b expected 0", BusyE); end
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (DoneE === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL kill_no_done: got %0d DoneE cycles expected 0", ndone); end
    checks++; if (ResultE !== last_res) begin errors++; $display("FAIL kill_result_kept: got %h expected %h", ResultE, last_res); end
    // Kill a multiply, then present a new op in the very next cycle.
    @(negedge clk);
    FunctE = 3'd3; SrcAE = $urandom; SrcBE = $urandom; StartE = 1'b1;
    repeat (5) @(negedge clk);
    Kill = 1'b1;
    a = 32'hFFFF_FF9C;
    b = 32'd7;
    exp = ref_op(3'd6, a, b);
    run_op(3'd6, a, b, res, lat, busy, seen);
    checks++; if (res !== exp) begin errors++; $display("FAIL kill_restart_result: got %h expected %h", res, exp); end
    checks++; if (lat != 33) begin errors++; $display("FAIL kill_restart_latency: got %0d expected 33", lat); end
    last_res = exp;
  endtask

  task automatic test_random();
    logic [31:0] res, exp, a, b;
    logic [2:0] f;
    int lat, busy, elat;
    logic seen;
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      exp = ref_op(f, a, b);
      elat = ref_lat(f, a, b);
      run_op(f, a, b, res, lat, busy, seen);
      checks++; if (!seen || res !== exp) begin errors++; $display("FAIL rnd%0d_result f=%0d a=%h b=%h: got %h expected %h", i, f, a, b, res, exp); end
      checks++; if (lat != elat || busy != elat) begin errors++; $display("FAIL rnd%0d_timing: got lat %0d busy %0d expected %0d", i, lat, busy, elat); end
      last_res = exp;
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    @(negedge clk);
    FunctE = 3'd1; SrcAE = $urandom; SrcBE = $urandom; StartE = 1'b1; HoldE = 1'b0; Kill = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; StartE = 1'b0;
    #1;
    checks++; if (BusyE !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", BusyE); end
    checks++; if (ResultE !== 32'd0) begin errors++; $display("FAIL rstmid_result: got %h expected 0", ResultE); end
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (DoneE === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d DoneE cycles expected 0", ndone); end
  endtask

  initial begin
    rst = 1'b1; StartE = 1'b0; HoldE = 1'b0; Kill = 1'b0;
    FunctE = 3'd0; SrcAE = 32'd0; SrcBE = 32'd0; last_res = 32'd0;
    test_reset();
    test_directed();
    test_hold();
    test_kill();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Execute-stage iterative multiply/divide unit for the RV32M extension. It consumes the M-type instruction fields and forwarded operands that the ID/EX pipeline register presents to the execute stage. It computes the result over multiple cycles and requests a pipeline stall from the hazard unit while busy. The result is muxed into the execute-stage ALU result path ahead of the EX/MEM register.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset; synchronous, active-high.
- StartE  input  1  execute-stage instruction is a valid (non-bubble) M-type op.
- FunctE  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- SrcAE  input  32  rs1 operand after forwarding.
- SrcBE  input  32  rs2 operand after forwarding.
- HoldE  input  1  EX/MEM register not enabled this cycle (downstream stall).
- Kill  input  1  flush of execute stage (branch/exception); aborts operation.
- BusyE  output  1  stall request to hazard unit; combinational.
- DoneE  output  1  ResultE valid for the instruction currently in EX.
- ResultE  output  32  registered result.

## Operation
- FSM states: IDLE, MUL, DIV, DONE. 5-bit iteration counter.
- Priority each cycle: rst > Kill > normal operation.
- IDLE + StartE: latch FunctE and operands; go to MUL (funct3[2]=0) or DIV (funct3[2]=1); counter = 31.
- Sign handling: signed operands are converted to magnitudes at start. MULHSU treats rs1 as signed and rs2 as unsigned. The final sign fix is applied when entering DONE.
- MUL: radix-2 shift-add over a 64-bit accumulator, one bit per cycle. MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- DIV: restoring division, one quotient bit per cycle. Quotient sign = signA XOR signB; remainder sign = signA.
- Fast path at start, going directly to DONE:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = SrcAE.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- Counter reaching 0 in MUL/DIV: next state DONE; ResultE loaded.
- DONE: DoneE = 1.
  - HoldE = 1: stay in DONE.
  - HoldE = 0: go to IDLE. StartE is ignored in DONE, so the stalled instruction is never re-executed.
- Kill in any state: next state IDLE, DoneE not asserted, ResultE unchanged.
- BusyE = !rst && ((IDLE && StartE && !Kill) || MUL || DIV).
- ResultE holds its value until the next DONE load.
- Reset values: state IDLE, ResultE 0, DoneE 0, BusyE 0, counter 0.

## Timing
- Start accepted at cycle T: BusyE = 1 at T (same cycle), stalling IF/ID and ID/EX.
- Iterations run at T+1..T+32; DONE at T+33 with DoneE = 1 and BusyE = 0. Total stall: 33 cycles.
- Fast-path division: DONE at T+1; stall of 1 cycle.
- Back-to-back M ops: the second starts in the first cycle its StartE is seen in IDLE, i.e. T+34 at the earliest.
- Kill at cycle K: BusyE drops at K+1. StartE at K+1 is accepted normally.
- rst asserted mid-operation: IDLE on the next edge; no DoneE pulse.

## Structure
- Shared package rv32m_pkg:
  - funct3 encodings (MUL..REMU).
  - FSM state encoding.
  - DIV_ZERO_Q = 32'hFFFFFFFF and INT_MIN = 32'h80000000 constants.
- One sub-module, div_restoring_step: a combinational single-iteration divider step (remainder shift, subtract, quotient bit). It is instantiated once; the top level holds the FSM, sign logic and multiply datapath.

## Test plan
- MUL 7 × 0xFFFFFFFD at T → BusyE 1 over T..T+32; DoneE at T+33 with ResultE 0xFFFFFFEB.
- MULH 0x80000000 × 0x80000000 → ResultE 0x40000000. MULHU same operands → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → DoneE at T+1, ResultE 0x80000000. REM same operands → 0. DIVU 5/0 → 0xFFFFFFFF. REMU 5/0 → 5.
- REM 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFF. DIV same operands → 0xFFFFFFFD. Both at T+33.
- Kill asserted at T+10 of a DIV → IDLE at T+11, BusyE 0, no DoneE, ResultE unchanged.
- DONE with HoldE = 1 for 3 cycles and StartE held high → DoneE high for 4 cycles, no restart; IDLE after HoldE drops.
